multi_mem_arbiter: RTL

Parametrised memory controller joining `CPUS` cores' instruction and data ports to a single RAM port. Data requests beat instruction requests. Within each class, cores are served round-robin. A starvation counter forces an instruction grant after a bounded run of data grants. Sits between the per-core caches and `ram`, replacing the single-core two-requester memory controller.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/multi_mem_arbiter_rr_arbiter.sv | 37 +++
 rtl/multi_mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the multi-core memory arbiter: RAM handshake states,
// request kinds and arbiter FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IRD, DRD, DWR} memreq_t;
    typedef enum logic {IDLE, XFER} arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0] rot_s;
    logic [IW:0]  sum_s;

    // rotate so bit 0 is the pointer position, then take the lowest set bit
    always_comb begin
        rot_s     = N'({req, req} >> ptr);
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum_s     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                gnt_valid = 1'b1;
                sum_s     = {1'b0, ptr} + (IW+1)'(i);
                if (sum_s >= (IW+1)'(N)) begin
                    sum_s = sum_s - (IW+1)'(N);
                end else begin
                    sum_s = sum_s;
                end
                gnt_idx = sum_s[IW-1:0];
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/multi_mem_arbiter.sv
// Joins CPUS cores' instruction and data ports onto one RAM port. Data beats
// instruction, round-robin within a class, starvation counter forces fetches.
module multi_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int IMAX = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0][AW-1:0]  iaddr,
    input  logic [CPUS-1:0][AW-1:0]  daddr,
    input  logic [CPUS-1:0][DW-1:0]  dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS-1:0][DW-1:0]  iload,
    output logic [CPUS-1:0][DW-1:0]  dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [AW-1:0]            ramaddr,
    output logic [DW-1:0]            ramstore,
    input  logic [DW-1:0]            ramload,
    input  ramstate_t                ramstate
);

    localparam int IW = idx_w(CPUS);
    localparam int SW = $clog2(IMAX + 1);

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  core_q, core_d, dptr_q, dptr_d, iptr_q, iptr_d;
    memreq_t        type_q, type_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  store_q, store_d;
    logic [SW-1:0]  scnt_q, scnt_d;

    logic           dvalid_s, ivalid_s, pick_i_s, any_req_s, force_i_s;
    logic           still_s, done_s;
    logic [IW-1:0]  didx_s, iidx_s;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] c);
        return (c == IW'(CPUS - 1)) ? '0 : c + IW'(1);
    endfunction

    rr_arbiter #(.N(CPUS), .IW(IW)) u_darb (
        .req(dREN | dWEN), .ptr(dptr_q), .gnt_valid(dvalid_s), .gnt_idx(didx_s)
    );
    rr_arbiter #(.N(CPUS), .IW(IW)) u_iarb (
        .req(iREN), .ptr(iptr_q), .gnt_valid(ivalid_s), .gnt_idx(iidx_s)
    );

    assign force_i_s = (scnt_q == SW'(IMAX));
    assign pick_i_s  = ivalid_s & (force_i_s | ~dvalid_s);
    assign any_req_s = dvalid_s | ivalid_s;

    // state and latch registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            core_q  <= '0;
            type_q  <= IRD;
            addr_q  <= '0;
            store_q <= '0;
            dptr_q  <= '0;
            iptr_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
            scnt_q  <= scnt_d;
        end
    end

    // next state, latched grant, pointers and starvation count
    always_comb begin
        case (type_q)
            IRD:     still_s = iREN[core_q];
            DRD:     still_s = dREN[core_q];
            DWR:     still_s = dWEN[core_q];
            default: still_s = 1'b0;
        endcase
        // a completion in the same cycle as a dropped request still counts
        done_s = (state_q == XFER) && (ramstate == ACCESS) && !RST;

        case (state_q)
            IDLE:    state_d = any_req_s ? XFER : IDLE;
            XFER:    state_d = (ramstate == ACCESS || ramstate == ERROR || !still_s) ? IDLE : XFER;
            default: state_d = IDLE;
        endcase

        core_d  = core_q;
        type_d  = type_q;
        addr_d  = addr_q;
        store_d = store_q;
        if (state_q == IDLE && any_req_s) begin
            if (pick_i_s) begin
                core_d  = iidx_s;
                type_d  = IRD;
                addr_d  = iaddr[iidx_s];
                store_d = '0;
            end else begin
                core_d  = didx_s;
                type_d  = dWEN[didx_s] ? DWR : DRD;
                addr_d  = daddr[didx_s];
                store_d = dstore[didx_s];
            end
        end else begin
            core_d = core_q;
        end

        dptr_d = dptr_q;
        iptr_d = iptr_q;
        if (done_s) begin
            if (type_q == IRD) begin
                iptr_d = next_idx(core_q);
            end else begin
                dptr_d = next_idx(core_q);
            end
        end else begin
            dptr_d = dptr_q;
        end

        if (iREN == '0) begin
            scnt_d = '0;
        end else if (done_s && type_q == IRD) begin
            scnt_d = '0;
        end else if (done_s && !force_i_s) begin
            scnt_d = scnt_q + SW'(1);
        end else begin
            scnt_d = scnt_q;
        end
    end

    // RAM port drive and per-core completion strobes
    always_comb begin
        ramREN   = (state_q == XFER) && (type_q != DWR);
        ramWEN   = (state_q == XFER) && (type_q == DWR);
        ramaddr  = (state_q == XFER) ? addr_q : '0;
        ramstore = (state_q == XFER) ? store_q : '0;
        iwait    = '1;
        dwait    = '1;
        if (done_s) begin
            if (type_q == IRD) begin
                iwait[core_q] = 1'b0;
            end else begin
                dwait[core_q] = 1'b0;
            end
        end else begin
            iwait = '1;
        end
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

endmodule
